// File: rtl/fir_poly_ctrl_pkg.sv
// Shared definitions for the polyphase FIR decimator MAC sequencer:
// default sweep geometry, FSM encoding and the per-issue flag bundle.
package fir_poly_ctrl_pkg;

    localparam int POLY_BANK_LEN_DEF      = 60;
    localparam int POLY_BANK_LEN_LOG2_DEF = 6;
    localparam int PIPE_LATENCY_DEF       = 4;
    localparam int OVR_CNT_WIDTH_DEF      = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // One entry per issue cycle, travelling alongside the ROM/multiplier data
    typedef struct packed {
        logic rd;
        logic first;
        logic last;
    } tap_flags_t;

endpackage

// File: rtl/fir_poly_ctrl_dly.sv
// Flag delay line matching the ROM + multiplier latency. Each stage holds
// the {rd, first, last} flags of one issue cycle, so overlapping sweeps
// stay separate.
module fir_poly_ctrl_dly
    import fir_poly_ctrl_pkg::*;
#(
    parameter int DEPTH = PIPE_LATENCY_DEF
) (
    input  logic       clk_i,
    input  logic       clr_i,
    input  logic [2:0] flags_i,
    output logic [2:0] flags_o,
    output logic       any_rd_o
);

    tap_flags_t [DEPTH-1:0] pipe;

    // Shift flags one stage per clock; clear empties the whole line
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            pipe <= '0;
        end else begin
            pipe[0] <= flags_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Any issued read still in flight keeps the sequencer busy
    always_comb begin
        any_rd_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_rd_o = any_rd_o | pipe[i].rd;
        end
    end

    assign flags_o = pipe[DEPTH-1];

endmodule

// File: rtl/fir_poly_ctrl.sv
// Tap sweep sequencer for the polyphase FIR decimator MAC datapath.
// Each accepted output-rate strobe sweeps the coefficient ROM address over
// all taps, drives accumulator clear/enable in step with the pipeline and
// flags the final bank sums. Strobes arriving mid-sweep are counted as
// overruns.
module fir_poly_ctrl
    import fir_poly_ctrl_pkg::*;
#(
    parameter int POLY_BANK_LEN      = POLY_BANK_LEN_DEF,
    parameter int POLY_BANK_LEN_LOG2 = POLY_BANK_LEN_LOG2_DEF,
    parameter int PIPE_LATENCY       = PIPE_LATENCY_DEF,
    parameter int OVR_CNT_WIDTH      = OVR_CNT_WIDTH_DEF
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          ce_i,
    input  logic                          sample_en_i,
    input  logic                          ovr_clr_i,
    output logic [POLY_BANK_LEN_LOG2-1:0] tap_addr_o,
    output logic                          tap_rd_o,
    output logic                          acc_clr_o,
    output logic                          acc_en_o,
    output logic                          sum_vld_o,
    output logic                          busy_o,
    output logic                          ovr_o,
    output logic [OVR_CNT_WIDTH-1:0]      ovr_cnt_o
);

    localparam logic [POLY_BANK_LEN_LOG2-1:0] LAST_ADDR =
        POLY_BANK_LEN_LOG2'(POLY_BANK_LEN - 1);

    state_t                        state_q, state_d;
    logic [POLY_BANK_LEN_LOG2-1:0] cnt_q;
    logic                          running, at_last, accept, ovr_evt;
    logic                          flush;
    tap_flags_t                    dly_in, dly_out;
    logic                          dly_any_rd;
    logic                          sum_vld_q, ovr_q;
    logic [OVR_CNT_WIDTH-1:0]      ovr_cnt_q;

    // Reset and a low enable both return the sequencer to a clean idle state
    assign flush = !rst_n_i || !ce_i;

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (flush) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a strobe on the last issue cycle chains the next sweep
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (sample_en_i) state_d = ST_RUN;
            ST_RUN:  if (at_last && !sample_en_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM decode: strobe accept vs. overrun, per-issue flags
    always_comb begin
        running = (state_q == ST_RUN);
        at_last = running && (cnt_q == LAST_ADDR);
        accept  = sample_en_i && (!running || at_last);
        ovr_evt = sample_en_i && running && !at_last;
        dly_in  = '{rd: running, first: running && (cnt_q == '0), last: at_last};
    end

    // Tap address counter; rests at 0 whenever no sweep is issuing
    always_ff @(posedge clk_i) begin
        if (flush) begin
            cnt_q <= '0;
        end else if (accept || at_last) begin
            cnt_q <= '0;
        end else if (running) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    fir_poly_ctrl_dly #(
        .DEPTH (PIPE_LATENCY)
    ) u_dly (
        .clk_i    (clk_i),
        .clr_i    (flush),
        .flags_i  (dly_in),
        .flags_o  (dly_out),
        .any_rd_o (dly_any_rd)
    );

    // Result valid lines up with the accumulator output register
    always_ff @(posedge clk_i) begin
        if (flush) begin
            sum_vld_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            sum_vld_q <= dly_out.last;
            ovr_q     <= ovr_evt;
        end
    end

    // Saturating overrun counter; holds while disabled, clear + event gives 1
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ovr_cnt_q <= '0;
        end else if (ce_i) begin
            if (ovr_evt) begin
                if (ovr_clr_i) begin
                    ovr_cnt_q <= OVR_CNT_WIDTH'(1);
                end else if (ovr_cnt_q != '1) begin
                    ovr_cnt_q <= ovr_cnt_q + 1'b1;
                end
            end else if (ovr_clr_i) begin
                ovr_cnt_q <= '0;
            end
        end
    end

    assign tap_addr_o = cnt_q;
    assign tap_rd_o   = running;
    assign acc_en_o   = dly_out.rd;
    assign acc_clr_o  = dly_out.rd && dly_out.first;
    assign sum_vld_o  = sum_vld_q;
    assign busy_o     = running || dly_any_rd || sum_vld_q;
    assign ovr_o      = ovr_q;
    assign ovr_cnt_o  = ovr_cnt_q;

endmodule
